// File: rtl/uart_pkg.sv
// Shared definitions for the UART-to-ALU command interface: opcodes, FSM encoding
// and default widths.
package uart_pkg;

    localparam int unsigned NB_DATA_DEF = 8;
    localparam int unsigned NB_OP_DEF   = 6;

    localparam logic [5:0] OpAdd = 6'h20;
    localparam logic [5:0] OpSub = 6'h22;
    localparam logic [5:0] OpAnd = 6'h24;
    localparam logic [5:0] OpOr  = 6'h25;
    localparam logic [5:0] OpXor = 6'h26;
    localparam logic [5:0] OpNor = 6'h27;
    localparam logic [5:0] OpSra = 6'h03;
    localparam logic [5:0] OpSrl = 6'h02;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWaitB  = 3'd1,
        StWaitOp = 3'd2,
        StExec   = 3'd3,
        StSend   = 3'd4,
        StWaitTx = 3'd5
    } state_e;

    function automatic logic is_valid_op(input logic [5:0] op);
        case (op)
            OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNor, OpSra, OpSrl: is_valid_op = 1'b1;
            default:                                               is_valid_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/intf_timer.sv
// Inter-byte timeout counter: counts enabled cycles, flags expiry at CLK_TIMEOUT-1.
module intf_timer #(
    parameter int unsigned CLK_TIMEOUT = 1000000,
    localparam int unsigned NB_CNT     = $clog2(CLK_TIMEOUT)
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [NB_CNT-1:0] Limit = NB_CNT'(CLK_TIMEOUT - 1);

    logic [NB_CNT-1:0] count_q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else if (i_clear) begin
            count_q <= '0;
        end else if (i_enable) begin
            count_q <= count_q + NB_CNT'(1);
        end
    end

    // The owner leaves the counting states on expiry, so the counter never wraps.
    assign o_expired = i_enable && !i_clear && (count_q == Limit);

endmodule

// File: rtl/uart_alu_intf.sv
// Assembles operand A, operand B and opcode bytes from uart_rx into an ALU command
// and launches one uart_tx transmission of the result per command.
module uart_alu_intf
    import uart_pkg::*;
#(
    parameter int unsigned NB_DATA     = NB_DATA_DEF,
    parameter int unsigned NB_OP       = NB_OP_DEF,
    parameter int unsigned CLK_TIMEOUT = 1000000
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_err
);

    state_e             state_q, state_d;
    logic               rx_done_q;
    logic [NB_DATA-1:0] alu_a_q, alu_a_d;
    logic [NB_DATA-1:0] alu_b_q, alu_b_d;
    logic [NB_OP-1:0]   alu_op_q, alu_op_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q;
    logic               busy_q;
    logic               err_q, err_d;

    logic             byte_event;
    logic [NB_OP-1:0] rx_op;
    logic             timer_en;
    logic             timer_clr;
    logic             timer_expired;

    // A level-held rx_done counts as a single byte.
    assign byte_event = i_rx_done && !rx_done_q;
    assign rx_op      = i_rx_data[NB_OP-1:0];
    assign timer_en   = (state_q == StWaitB) || (state_q == StWaitOp);
    assign timer_clr  = byte_event || !timer_en;

    intf_timer #(
        .CLK_TIMEOUT(CLK_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (timer_clr),
        .i_enable (timer_en),
        .o_expired(timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        tx_data_d = tx_data_q;
        err_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (byte_event) begin
                    alu_a_d = i_rx_data;
                    state_d = StWaitB;
                end
            end
            StWaitB: begin
                if (byte_event) begin
                    alu_b_d = i_rx_data;
                    state_d = StWaitOp;
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StWaitOp: begin
                if (byte_event) begin
                    if (is_valid_op(6'(rx_op))) begin
                        alu_op_d = rx_op;
                        state_d  = StExec;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StExec: begin
                tx_data_d = i_alu_result;
                err_d     = byte_event;
                state_d   = StSend;
            end
            StSend: begin
                err_d   = byte_event;
                state_d = StWaitTx;
            end
            StWaitTx: begin
                err_d = byte_event;
                if (i_tx_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            rx_done_q  <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_done_q  <= i_rx_done;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= (state_d == StSend);
            busy_q     <= (state_d != StIdle);
            err_q      <= err_d;
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_err      = err_q;

endmodule
